// File: rtl/lsu_mio_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the lsu_mio load/store unit:
//   - lsu_f3_e    : RISC-V funct3 load/store type codes
//   - lsu_state_e : access FSM state encoding (also exported as a debug port)
//   - size_bytes  : funct3 -> access size in bytes (1 << funct3[1:0])
//   - type_illegal: funct3 codes the datapath width cannot serve
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B   = 3'b000,
    F3_H   = 3'b001,
    F3_W   = 3'b010,
    F3_D   = 3'b011,
    F3_BU  = 3'b100,
    F3_HU  = 3'b101,
    F3_WU  = 3'b110,
    F3_BAD = 3'b111
  } lsu_f3_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Access size in bytes; bit 2 of funct3 only selects zero extension.
  function automatic logic [3:0] size_bytes(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction

  // 111 is never legal; d and wu only exist on a 64-bit datapath.
  function automatic logic type_illegal(input logic [2:0] f3, input int xlen);
    return (f3 == F3_BAD) || ((xlen == 32) && ((f3 == F3_D) || (f3 == F3_WU)));
  endfunction

endpackage

// File: rtl/lsu_mio_if.sv
// -----------------------------------------------------------------------------
// lsu_mio_if
// Bundles the CPU request/response handshake and the memory/MIO bus beat
// signals of lsu_mio.
//   slave  modport : the load/store unit itself
//   master modport : the CPU datapath plus the memory responder
// Request side : req_valid, req_ready, req_we, req_type, req_addr, req_wdata
// Response side: resp_valid, resp_rdata, resp_err
// Bus side     : mem_req, mem_w, wea, Addr_out, Data_out, Data_in, MIO_ready
// -----------------------------------------------------------------------------
interface lsu_mio_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_type;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;

  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;

  logic              mem_req;
  logic              mem_w;
  logic [NB-1:0]     wea;
  logic [ADDR_W-1:0] Addr_out;
  logic [XLEN-1:0]   Data_out;
  logic [XLEN-1:0]   Data_in;
  logic              MIO_ready;

  modport slave (
    input  req_valid, req_we, req_type, req_addr, req_wdata, Data_in, MIO_ready,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_w, wea, Addr_out, Data_out
  );

  modport master (
    output req_valid, req_we, req_type, req_addr, req_wdata, Data_in, MIO_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_w, wea, Addr_out, Data_out
  );

endinterface

// File: rtl/lsu_mio_lane.sv
// -----------------------------------------------------------------------------
// lsu_lane
// Combinational byte-lane steering for lsu_mio.
//   i_off    : byte offset of the access inside the bus word
//   i_type   : funct3 of the access (size and sign/zero extension)
//   i_beat1  : 1 while the second beat of a split access is on the bus
//   i_wdata  : right-aligned store data
//   i_lo/i_hi: read data captured in beat 0 / beat 1
//   o_wea    : byte write enables for the current beat
//   o_data   : lane-shifted write data for the current beat
//   o_rdata  : merged, truncated and extended load result
// -----------------------------------------------------------------------------
module lsu_lane
  import lsu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OW   = $clog2(NB)
) (
  input  logic [OW-1:0]   i_off,
  input  logic [2:0]      i_type,
  input  logic            i_beat1,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_hi,
  output logic [NB-1:0]   o_wea,
  output logic [XLEN-1:0] o_data,
  output logic [XLEN-1:0] o_rdata
);

  localparam logic [OW:0] C_NB = (OW+1)'(NB);

  logic [3:0]      w_size;
  logic [4:0]      w_end;
  logic [OW:0]     w_noff;
  logic [XLEN-1:0] w_sh;
  logic [XLEN-1:0] w_mask;
  logic [XLEN-1:0] w_top;
  logic            w_sbit;

  assign w_size = size_bytes(i_type);
  // One past the last byte of the access, counted from the beat-0 word.
  assign w_end  = 5'(i_off) + 5'(w_size);
  assign w_noff = C_NB - {1'b0, i_off};

  // Beat 0 covers bytes [off, end) clipped to the word; beat 1 covers the
  // spill-over, i.e. byte i of the next word when i + NB < end.
  always_comb begin
    o_wea = '0;
    for (int i = 0; i < NB; i++) begin
      if (i_beat1) o_wea[i] = (5'(i) + 5'(NB)) < w_end;
      else         o_wea[i] = (5'(i) >= 5'(i_off)) && (5'(i) < w_end);
    end
  end

  assign o_data = i_beat1 ? (i_wdata >> {w_noff, 3'b000})
                          : (i_wdata << {i_off, 3'b000});

  // Load: bring the addressed byte to lane 0, keep S bytes, extend from the
  // top kept bit. w_top isolates the most significant bit of the mask.
  assign w_sh   = XLEN'({i_hi, i_lo} >> {i_off, 3'b000});
  assign w_mask = ~({XLEN{1'b1}} << {w_size, 3'b000});
  assign w_top  = w_mask & ~(w_mask >> 1);
  assign w_sbit = |(w_sh & w_top);

  assign o_rdata = (w_sh & w_mask) | ((!i_type[2] && w_sbit) ? ~w_mask : '0);

endmodule

// File: rtl/lsu_mio.sv
// -----------------------------------------------------------------------------
// lsu_mio
// Multi-cycle load/store engine between the CPU datapath and the memory/MIO
// bus. Accepts one request at a time, issues one or two bus beats, and returns
// a one-cycle response with extended load data or an error flag.
//   clk         : rising-edge clock
//   reset       : asynchronous, active-low reset
//   bus         : lsu_mio_if.slave (request, response and bus beat signals)
//   o_dbg_state : current FSM state, for observation only
// Optional feature macro: LSU_MISALIGN_EN
//   defined   -> misaligned accesses run in one beat, or two when they cross
//                the bus word
//   undefined -> misaligned accesses return resp_err with no bus beat
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is 1 only in IDLE. A bus beat completes on
// a rising edge where mem_req and MIO_ready are both 1; all bus outputs hold
// until then. resp_valid is a single-cycle pulse with no back-pressure.
// -----------------------------------------------------------------------------
module lsu_mio
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  lsu_mio_if.slave   bus,
  output lsu_state_e o_dbg_state
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  lsu_state_e        r_state;
  lsu_state_e        w_next;
  logic              r_we;
  logic [2:0]        r_type;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_lo;
  logic              r_err;

  logic              w_req_err;
  logic [ADDR_W-1:0] w_base;
  logic              w_beat1;
  logic [XLEN-1:0]   w_hi;
  logic [NB-1:0]     w_lane_wea;
  logic [XLEN-1:0]   w_lane_data;
  logic [XLEN-1:0]   w_lane_rdata;

`ifdef LSU_MISALIGN_EN
  logic [XLEN-1:0]   r_hi;
  logic              w_split;

  assign w_req_err = type_illegal(bus.req_type, XLEN);
  // The access spills into the next word when off + S exceeds the lane count.
  assign w_split   = (5'(r_addr[OW-1:0]) + 5'(size_bytes(r_type))) > 5'(NB);
  assign w_beat1   = (r_state == ST_BEAT1);
  assign w_hi      = r_hi;
`else
  logic [3:0]        w_req_size;
  logic              w_req_misalign;

  assign w_req_size     = size_bytes(bus.req_type);
  assign w_req_misalign = (OW'(w_req_size - 4'd1) & bus.req_addr[OW-1:0]) != '0;
  assign w_req_err      = type_illegal(bus.req_type, XLEN) || w_req_misalign;
  assign w_beat1        = 1'b0;
  assign w_hi           = '0;
`endif

  assign w_base      = {r_addr[ADDR_W-1:OW], {OW{1'b0}}};
  assign o_dbg_state = r_state;

  lsu_lane #(.XLEN(XLEN)) u_lane (
    .i_off   (r_addr[OW-1:0]),
    .i_type  (r_type),
    .i_beat1 (w_beat1),
    .i_wdata (r_wdata),
    .i_lo    (r_lo),
    .i_hi    (w_hi),
    .o_wea   (w_lane_wea),
    .o_data  (w_lane_data),
    .o_rdata (w_lane_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_type  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_lo    <= '0;
    end else begin
      if (r_state == ST_IDLE && bus.req_valid) begin
        r_we    <= bus.req_we;
        r_type  <= bus.req_type;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_err   <= w_req_err;
      end
      if (r_state == ST_BEAT0 && bus.MIO_ready) r_lo <= bus.Data_in;
    end
  end

`ifdef LSU_MISALIGN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    r_hi <= '0;
    else if (r_state == ST_BEAT1 && bus.MIO_ready) r_hi <= bus.Data_in;
  end
`endif

  always_comb begin
    w_next         = r_state;
    bus.req_ready  = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_w      = 1'b0;
    bus.wea        = '0;
    bus.Addr_out   = '0;
    bus.Data_out   = '0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_next = w_req_err ? ST_RESP : ST_BEAT0;
      end
      ST_BEAT0: begin
        bus.mem_req  = 1'b1;
        bus.mem_w    = r_we;
        bus.Addr_out = w_base;
        if (r_we) begin
          bus.wea      = w_lane_wea;
          bus.Data_out = w_lane_data;
        end
`ifdef LSU_MISALIGN_EN
        if (bus.MIO_ready) w_next = w_split ? ST_BEAT1 : ST_RESP;
`else
        if (bus.MIO_ready) w_next = ST_RESP;
`endif
      end
      ST_BEAT1: begin
`ifdef LSU_MISALIGN_EN
        bus.mem_req  = 1'b1;
        bus.mem_w    = r_we;
        bus.Addr_out = w_base + ADDR_W'(NB);
        if (r_we) begin
          bus.wea      = w_lane_wea;
          bus.Data_out = w_lane_data;
        end
        if (bus.MIO_ready) w_next = ST_RESP;
`else
        w_next = ST_IDLE;
`endif
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = r_err;
        if (!r_err && !r_we) bus.resp_rdata = w_lane_rdata;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mio.sv
// -----------------------------------------------------------------------------
// tb_lsu_mio
// Directed test-plan steps followed by randomized accesses for lsu_mio with
// XLEN=32. Expected bus beats and load results come from a byte-addressed
// memory model: an access touches bytes addr .. addr+S-1, each bus word that
// contains one of them is one beat. Honours LSU_MISALIGN_EN like the DUT.
// -----------------------------------------------------------------------------
module tb_lsu_mio;
  import lsu_pkg::*;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  lsu_state_e dbg_state;
  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] mem [64];

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  lsu_mio_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  lsu_mio #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- checking / model helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return mem[a[5:0]];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = rd_byte(a + 32'(k));
    return w;
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    logic [31:0] b;
    for (int k = 0; k < 4; k++) begin
      b = a + 32'(k);
      mem[b[5:0]] = v[8*k +: 8];
    end
  endtask

  // ---------------- driver + per-access scoreboard ----------------
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input int stall,
                            output logic [31:0] rdata_o, output logic err_o);
    int          s, nbeats, c, beat_idx, stall_left;
    logic        illegal, err, got;
    logic [31:0] exp_load, baddr, k, exp_dat, exp_mask, b;
    logic [3:0]  exp_wea;

    s       = 1 << f3[1:0];
    illegal = (f3 == 3'b111) || (f3 == 3'b011) || (f3 == 3'b110);
`ifdef LSU_MISALIGN_EN
    err = illegal;
`else
    err = illegal || ((addr & 32'(s - 1)) != 0);
`endif
    nbeats   = err ? 0 : ((int'(addr & 32'd3) + s > 4) ? 2 : 1);
    exp_load = '0;
    if (!err) begin
      for (int j = 0; j < s; j++) exp_load[8*j +: 8] = rd_byte(addr + 32'(j));
      if (!f3[2] && s < 4 && exp_load[8*s-1])
        for (int j = s; j < 4; j++) exp_load[8*j +: 8] = 8'hFF;
    end

    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_type  = f3;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_type  = 3'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;

    c = 0; beat_idx = 0; stall_left = stall; got = 1'b0;
    rdata_o = '0; err_o = 1'b0;
    while (!got && c < 40) begin
      @(negedge clk);
      c++;
      if (c == 1) chk("req_ready_busy", bus.req_ready, 0);
      if (bus.mem_req) begin
        if (beat_idx < nbeats) begin
          baddr    = (addr & ~32'd3) + 32'(4 * beat_idx);
          exp_wea  = '0;
          exp_dat  = '0;
          exp_mask = '0;
          for (int i = 0; i < 4; i++) begin
            k = baddr + 32'(i) - addr;
            if (k < 32'(s)) begin
              exp_wea[i]          = we;
              exp_mask[8*i +: 8]  = 8'hFF;
              exp_dat[8*i +: 8]   = wdata[8*k +: 8];
            end
          end
          chk("beat_addr", bus.Addr_out, baddr);
          chk("beat_w", bus.mem_w, we);
          chk("beat_wea", bus.wea, exp_wea);
          if (we) chk("beat_data", bus.Data_out & exp_mask, exp_dat);
        end else begin
          chk("unexpected_beat", bus.mem_req, 0);
        end
        if (stall_left > 0) begin
          bus.MIO_ready = 1'b0;
          bus.Data_in   = $urandom;
          stall_left--;
        end else begin
          bus.MIO_ready = 1'b1;
          bus.Data_in   = word_at(bus.Addr_out);
          if (bus.mem_w)
            for (int i = 0; i < 4; i++)
              if (bus.wea[i]) begin
                b = bus.Addr_out + 32'(i);
                mem[b[5:0]] = bus.Data_out[8*i +: 8];
              end
          beat_idx++;
        end
      end else begin
        bus.MIO_ready = 1'($urandom);
        bus.Data_in   = $urandom;
      end
      if (bus.resp_valid) begin
        got = 1'b1;
        rdata_o = bus.resp_rdata;
        err_o   = bus.resp_err;
        chk("resp_err", bus.resp_err, err);
        chk("resp_rdata", bus.resp_rdata, (err || we) ? 32'd0 : exp_load);
        chk("resp_latency", c, err ? 1 : 1 + nbeats + stall);
        chk("beat_count", beat_idx, nbeats);
      end
    end
    chk("resp_seen", got, 1);
    @(negedge clk);
    bus.MIO_ready = 1'($urandom);
    chk("resp_one_cycle", bus.resp_valid, 0);
    chk("req_ready_after", bus.req_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        er;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_type  = 3'b000;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.Data_in   = '0;
    bus.MIO_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_state", dbg_state, ST_IDLE);
    chk("idle_req_ready", bus.req_ready, 1);
    chk("idle_outputs", {bus.mem_w, bus.wea, bus.resp_err}, 0);
    chk("idle_addr_data", {bus.Addr_out, bus.Data_out, bus.resp_rdata}, 0);

    // 1: aligned word store
    run_access(1'b1, 3'b010, 32'h100, 32'h12345678, 0, rd, er);
    chk("tp1_err", er, 0);

    // 2: byte loads, signed and unsigned
    set_word(32'h100, 32'h80FFFF00);
    run_access(1'b0, 3'b000, 32'h103, 32'h0, 0, rd, er);
    chk("tp2_lb", rd, 32'hFFFFFF80);
    run_access(1'b0, 3'b100, 32'h103, 32'h0, 0, rd, er);
    chk("tp2_lbu", rd, 32'h00000080);

    // 3: halfword stores, aligned and misaligned
    run_access(1'b1, 3'b001, 32'h102, 32'h0000BEEF, 0, rd, er);
    chk("tp3_sh_aligned_err", er, 0);
    run_access(1'b1, 3'b001, 32'h101, 32'h0000BEEF, 0, rd, er);
`ifdef LSU_MISALIGN_EN
    chk("tp3_sh_mis_err", er, 0);
`else
    chk("tp3_sh_mis_err", er, 1);
`endif

    // 4: word accesses crossing the bus word, and the address wrap
    set_word(32'h100, 32'h55667788);
    set_word(32'h104, 32'h11223344);
    run_access(1'b0, 3'b010, 32'h102, 32'h0, 0, rd, er);
`ifdef LSU_MISALIGN_EN
    chk("tp4_lw_split", rd, 32'h33445566);
`else
    chk("tp4_lw_split_err", er, 1);
`endif
    run_access(1'b1, 3'b010, 32'h103, 32'hAABBCCDD, 0, rd, er);
    run_access(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 1, rd, er);

    // 5: stalled beat, then reset during a stalled beat
    run_access(1'b0, 3'b010, 32'h108, 32'h0, 3, rd, er);
    run_access(1'b1, 3'b000, 32'h10D, 32'h000000A5, 3, rd, er);

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_type  = 3'b010;
    bus.req_addr  = 32'h100;
    bus.MIO_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      bus.MIO_ready = 1'b0;
      chk("rst_wait_mem_req", bus.mem_req, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_drop_mem_req", bus.mem_req, 0);
    chk("rst_no_resp", bus.resp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.MIO_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_resp", bus.resp_valid, 0);
      chk("post_rst_ready", bus.req_ready, 1);
      chk("post_rst_mem_req", bus.mem_req, 0);
    end

    // 6: illegal types
    run_access(1'b0, 3'b011, 32'h100, 32'h0, 0, rd, er);
    chk("tp6_d_err", er, 1);
    run_access(1'b0, 3'b111, 32'h104, 32'h0, 0, rd, er);
    chk("tp6_111_err", er, 1);
    run_access(1'b1, 3'b110, 32'h108, 32'hDEADBEEF, 0, rd, er);

    // randomized accesses
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'h100 + 32'($urandom_range(0, 63));
      run_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                 $urandom_range(0, 2), rd, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
